crc_error_monitor: RTL and testbench

//  Consumer side of the post-configuration CRC checker's CRCERROR flag. Synchronises the

---
 rtl/crc_mon_pkg.sv | 14 +
 rtl/crc_mon_sync_filter.sv | 105 ++++++++++
 rtl/crc_error_monitor.sv | 60 ++++++
 tb/tb_crc_error_monitor.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_mon_pkg.sv
// Shared definitions for the CRC error monitor: filter state encoding and
// synchroniser depth.
package crc_mon_pkg;

   localparam int SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,   // qualified level 0, nothing pending
      QUAL_HI = 2'd1,   // qualified level 0, counting high samples
      ACTIVE  = 2'd2,   // qualified level 1, stable
      QUAL_LO = 2'd3    // qualified level 1, counting low samples
   } filt_state_t;

endpackage

// File: rtl/crc_mon_sync_filter.sv
// Two-flop synchroniser on the raw CRC error level followed by a run-length
// glitch filter. Produces the qualified level and a one-cycle pulse on each
// fresh qualification (entry to ACTIVE from the low side only).
module crc_mon_sync_filter
   import crc_mon_pkg::*;
#(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic evt
);

   localparam int FCW = $clog2(FILTER_LEN + 1);
   localparam logic [FCW-1:0] THRESH = FCW'(FILTER_LEN);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   sync_out;
   filt_state_t            state_reg, state_next;
   logic [FCW-1:0]         fcnt_reg, fcnt_next;
   logic                   hit;

   assign sync_out = sync_reg[SYNC_STAGES-1];
   // fcnt is cleared on reaching the threshold, so the increment never wraps
   assign hit      = (fcnt_reg + FCW'(1)) == THRESH;

   // Shift the asynchronous level through the synchroniser chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_reg <= '0;
      else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
   end

   // Next-state logic: the level flips only after FILTER_LEN equal samples
   always_comb begin
      state_next = state_reg;
      fcnt_next  = fcnt_reg;
      case (state_reg)
         IDLE: begin
            if (sync_out) begin
               if (FILTER_LEN == 1) begin
                  state_next = ACTIVE;
               end else begin
                  state_next = QUAL_HI;
                  fcnt_next  = FCW'(1);
               end
            end
         end
         QUAL_HI: begin
            if (!sync_out) begin
               state_next = IDLE;
               fcnt_next  = '0;
            end else if (hit) begin
               state_next = ACTIVE;
               fcnt_next  = '0;
            end else begin
               fcnt_next  = fcnt_reg + FCW'(1);
            end
         end
         ACTIVE: begin
            if (!sync_out) begin
               if (FILTER_LEN == 1) begin
                  state_next = IDLE;
               end else begin
                  state_next = QUAL_LO;
                  fcnt_next  = FCW'(1);
               end
            end
         end
         QUAL_LO: begin
            if (sync_out) begin
               state_next = ACTIVE;
               fcnt_next  = '0;
            end else if (hit) begin
               state_next = IDLE;
               fcnt_next  = '0;
            end else begin
               fcnt_next  = fcnt_reg + FCW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            fcnt_next  = '0;
         end
      endcase
   end

   // State, counter and registered outputs; re-entry from QUAL_LO is not an event
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         fcnt_reg  <= '0;
         level     <= 1'b0;
         evt       <= 1'b0;
      end else begin
         state_reg <= state_next;
         fcnt_reg  <= fcnt_next;
         level     <= (state_next == ACTIVE) || (state_next == QUAL_LO);
         evt       <= (state_next == ACTIVE) &&
                      ((state_reg == IDLE) || (state_reg == QUAL_HI));
      end
   end

endmodule

// File: rtl/crc_error_monitor.sv
// Consumer of the CRC checker's error flag: filtered level, saturating count
// of qualified error events and a level interrupt cleared by acknowledge.
module crc_error_monitor
   import crc_mon_pkg::*;
#(
   parameter int FILTER_LEN = 4,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                 CLK,
   input  logic                 RSTN,
   input  logic                 CRCERROR,
   input  logic                 INTERRUPT_ACK,
   input  logic                 CLEAR_COUNT,
   output logic                 INTERRUPT,
   output logic                 CRC_ERROR_ACTIVE,
   output logic [CNT_WIDTH-1:0] ERROR_COUNT,
   output logic                 COUNT_SAT
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   logic                 evt;
   logic [CNT_WIDTH-1:0] count_next;

   crc_mon_sync_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_filter (
      .clk   (CLK),
      .rst_n (RSTN),
      .raw   (CRCERROR),
      .level (CRC_ERROR_ACTIVE),
      .evt   (evt)
   );

   // Counter update: an event coinciding with a clear restarts the count at one
   always_comb begin
      count_next = ERROR_COUNT;
      if (evt) begin
         if (CLEAR_COUNT)                count_next = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         else if (ERROR_COUNT != CNT_MAX) count_next = ERROR_COUNT + 1'b1;
      end else if (CLEAR_COUNT) begin
         count_next = '0;
      end
   end

   // Count, saturation flag and interrupt; a new event beats a same-cycle acknowledge
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         ERROR_COUNT <= '0;
         COUNT_SAT   <= 1'b0;
         INTERRUPT   <= 1'b0;
      end else begin
         ERROR_COUNT <= count_next;
         COUNT_SAT   <= (count_next == CNT_MAX);
         if (evt)                INTERRUPT <= 1'b1;
         else if (INTERRUPT_ACK) INTERRUPT <= 1'b0;
      end
   end

endmodule

// File: tb/tb_crc_error_monitor.sv
// Bench for crc_error_monitor: three instances (default, 2-bit counter,
// FILTER_LEN=1) checked every cycle against a run-length reference model.
module tb_crc_error_monitor;

   localparam int N    = 3;
   localparam int HMAX = 8192;

   int flen [N] = '{4, 4, 1};
   int cmax [N] = '{255, 3, 255};

   logic       clk = 1'b0;
   logic       rstn;
   logic       crc  [N];
   logic       ack  [N];
   logic       clr  [N];
   logic       intr [N];
   logic       act  [N];
   logic       sat  [N];
   logic [7:0] cnt0, cnt2;
   logic [1:0] cnt1;
   logic [7:0] cntv [N];

   assign cntv[0] = cnt0;
   assign cntv[1] = {6'd0, cnt1};
   assign cntv[2] = cnt2;

   always #5 clk = ~clk;

   crc_error_monitor #(.FILTER_LEN(4), .CNT_WIDTH(8)) dut0 (
      .CLK(clk), .RSTN(rstn), .CRCERROR(crc[0]), .INTERRUPT_ACK(ack[0]),
      .CLEAR_COUNT(clr[0]), .INTERRUPT(intr[0]), .CRC_ERROR_ACTIVE(act[0]),
      .ERROR_COUNT(cnt0), .COUNT_SAT(sat[0]));

   crc_error_monitor #(.FILTER_LEN(4), .CNT_WIDTH(2)) dut1 (
      .CLK(clk), .RSTN(rstn), .CRCERROR(crc[1]), .INTERRUPT_ACK(ack[1]),
      .CLEAR_COUNT(clr[1]), .INTERRUPT(intr[1]), .CRC_ERROR_ACTIVE(act[1]),
      .ERROR_COUNT(cnt1), .COUNT_SAT(sat[1]));

   crc_error_monitor #(.FILTER_LEN(1), .CNT_WIDTH(8)) dut2 (
      .CLK(clk), .RSTN(rstn), .CRCERROR(crc[2]), .INTERRUPT_ACK(ack[2]),
      .CLEAR_COUNT(clr[2]), .INTERRUPT(intr[2]), .CRC_ERROR_ACTIVE(act[2]),
      .ERROR_COUNT(cnt2), .COUNT_SAT(sat[2]));

   // Reference model: raw input log since reset, synchronised sample is the
   // raw value two edges back; level flips after FILTER_LEN equal samples.
   bit raw_log [N][HMAX];
   int k_idx;
   bit m_q   [N];
   bit m_int [N];
   bit m_ev  [N];
   int m_cnt [N];
   bit run_val [N];
   int run_len [N];

   int total = 0;
   int bad   = 0;
   bit ack_follow = 1'b0;
   bit clr_follow = 1'b0;

   task automatic model_reset();
      k_idx = 0;
      for (int i = 0; i < N; i++) begin
         m_q[i] = 1'b0; m_int[i] = 1'b0; m_ev[i] = 1'b0; m_cnt[i] = 0;
         run_val[i] = 1'b0; run_len[i] = 0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < N; i++) begin
         bit s;
         bit nq;
         if (k_idx < HMAX) raw_log[i][k_idx] = crc[i];
         s = (k_idx >= 2 && k_idx - 2 < HMAX) ? raw_log[i][k_idx-2] : 1'b0;
         if (m_ev[i]) begin
            m_int[i] = 1'b1;
            if (clr[i])                  m_cnt[i] = 1;
            else if (m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
         end else begin
            if (ack[i]) m_int[i] = 1'b0;
            if (clr[i]) m_cnt[i] = 0;
         end
         if (s == run_val[i]) run_len[i] = run_len[i] + 1;
         else begin run_val[i] = s; run_len[i] = 1; end
         nq = m_q[i];
         if (run_val[i] != m_q[i] && run_len[i] >= flen[i]) nq = run_val[i];
         m_ev[i] = !m_q[i] && nq;
         m_q[i]  = nq;
      end
      k_idx++;
   endtask

   task automatic check_all(string tag);
      for (int i = 0; i < N; i++) begin
         total++;
         assert (intr[i] === m_int[i]) else begin
            bad++; $error("FAIL %s intr[%0d] got=%b want=%b", tag, i, intr[i], m_int[i]);
         end
         total++;
         assert (act[i] === m_q[i]) else begin
            bad++; $error("FAIL %s active[%0d] got=%b want=%b", tag, i, act[i], m_q[i]);
         end
         total++;
         assert (cntv[i] === 8'(m_cnt[i])) else begin
            bad++; $error("FAIL %s count[%0d] got=%0d want=%0d", tag, i, cntv[i], m_cnt[i]);
         end
         total++;
         assert (sat[i] === (m_cnt[i] == cmax[i])) else begin
            bad++; $error("FAIL %s sat[%0d] got=%b want=%b", tag, i, sat[i], m_cnt[i] == cmax[i]);
         end
      end
   endtask

   task automatic expect_val(string tag, logic [15:0] got, logic [15:0] want);
      total++;
      assert (got === want) else begin
         bad++; $error("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   task automatic tick(string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         ack[i] = ack_follow ? m_ev[i] : 1'b0;
         clr[i] = clr_follow ? m_ev[i] : 1'b0;
      end
   endtask

   task automatic run(string tag, int n);
      for (int j = 0; j < n; j++) tick(tag);
   endtask

   task automatic set_crc(logic v);
      for (int i = 0; i < N; i++) crc[i] = v;
   endtask

   task automatic pulse_ack(string tag);
      for (int i = 0; i < N; i++) ack[i] = 1'b1;
      tick(tag);
   endtask

   task automatic pulse_clr(string tag);
      for (int i = 0; i < N; i++) clr[i] = 1'b1;
      tick(tag);
   endtask

   initial begin
      logic [7:0] c_save;

      // Reset held with the error input already high
      rstn = 1'b0;
      set_crc(1'b1);
      for (int i = 0; i < N; i++) begin ack[i] = 1'b0; clr[i] = 1'b0; end
      @(negedge clk);
      @(negedge clk);
      model_reset();
      check_all("reset");
      rstn = 1'b1;
      $display("step: reset released with CRCERROR high");
      for (int e = 1; e <= 7; e++) begin
         tick("requal");
         if (e == 3) expect_val("l1_active_e3", act[2], 1);
         if (e == 4) expect_val("l1_intr_e4", intr[2], 1);
         if (e == 5) expect_val("active_e5", act[0], 0);
         if (e == 6) begin
            expect_val("active_e6", act[0], 1);
            expect_val("intr_e6", intr[0], 0);
         end
         if (e == 7) begin
            expect_val("intr_e7", intr[0], 1);
            expect_val("count_e7", cnt0, 1);
         end
      end

      // Glitch rejection
      $display("step: glitch filter");
      pulse_ack("ack0");
      expect_val("ack_clears", intr[0], 0);
      set_crc(1'b0);
      run("fall", 10);
      pulse_clr("clr0");
      expect_val("clr_zero", cnt0, 0);
      set_crc(1'b1);
      run("glitch_hi", 3);
      set_crc(1'b0);
      run("glitch_lo", 12);
      expect_val("glitch_intr", intr[0], 0);
      expect_val("glitch_count", cnt0, 0);
      set_crc(1'b1);
      run("long_hi", 8);
      expect_val("long_active", act[0], 1);
      expect_val("long_count", cnt0, 1);

      // Handshake, acknowledge coincident with a new event
      $display("step: interrupt handshake");
      pulse_ack("ack1");
      expect_val("ack1_clears", intr[0], 0);
      ack_follow = 1'b1;
      set_crc(1'b0);
      run("hs_lo", 12);
      set_crc(1'b1);
      run("hs_hi", 10);
      ack_follow = 1'b0;
      expect_val("hs_intr_kept", intr[0], 1);
      expect_val("hs_count", cnt0, 2);

      // Saturation on the 2-bit counter
      $display("step: counter saturation");
      for (int p = 1; p <= 5; p++) begin
         set_crc(1'b0);
         run("sat_lo", 10);
         set_crc(1'b1);
         run("sat_hi", 8);
         if (p == 3) begin
            expect_val("sat3_count", cnt1, 3);
            expect_val("sat3_flag", sat[1], 1);
         end
      end
      expect_val("sat5_count", cnt1, 3);
      expect_val("sat5_intr", intr[1], 1);
      clr_follow = 1'b1;
      set_crc(1'b0);
      run("clrev_lo", 10);
      set_crc(1'b1);
      run("clrev_hi", 8);
      clr_follow = 1'b0;
      expect_val("clrev_count", cnt1, 1);
      expect_val("clrev_sat", sat[1], 0);
      pulse_clr("clr1");
      expect_val("clr1_count", cnt1, 0);
      expect_val("clr1_sat", sat[1], 0);

      // Short drop-out while active, then a real fall
      $display("step: drop-out handling");
      c_save = cnt0;
      set_crc(1'b0);
      run("drop_lo", 2);
      set_crc(1'b1);
      for (int e = 0; e < 10; e++) begin
         tick("drop_hi");
         expect_val("drop_active", act[0], 1);
      end
      expect_val("drop_count", cnt0, 16'(c_save));
      set_crc(1'b0);
      for (int e = 1; e <= 8; e++) begin
         tick("fall_lat");
         if (e == 5) expect_val("fall_e5", act[0], 1);
         if (e == 6) expect_val("fall_e6", act[0], 0);
      end

      // Single-cycle pulse with FILTER_LEN=1
      $display("step: single-sample filter");
      pulse_ack("ack2");
      c_save = cnt2;
      crc[2] = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick("l1_pulse");
         crc[2] = 1'b0;
         if (e == 2) expect_val("l1_e2_active", act[2], 0);
         if (e == 3) expect_val("l1_e3_active", act[2], 1);
         if (e == 4) begin
            expect_val("l1_e4_active", act[2], 0);
            expect_val("l1_e4_intr", intr[2], 1);
         end
      end
      expect_val("l1_count", cnt2, 16'(c_save + 8'd1));

      // Randomised traffic with a reset in the middle
      $display("step: random traffic");
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(5, 0) == 0) crc[i] = ~crc[i];
            ack[i] = ($urandom_range(7, 0) == 0);
            clr[i] = ($urandom_range(39, 0) == 0);
         end
         if (c == 1500) begin
            rstn = 1'b0;
            #1;
            model_reset();
            check_all("rst_mid");
            @(negedge clk);
            @(negedge clk);
            rstn = 1'b1;
         end
         tick("random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
